// File: rtl/mem_ctrl_if.sv
// Request/response and byte-wide RAM bus signals for mem_ctrl.
// master = MEM stage plus RAM side; slave = the controller.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_i;
  logic              we_i;
  logic [ADDR_W-1:0] addr_i;
  logic [1:0]        size_i;
  logic              unsigned_i;
  logic [31:0]       wdata_i;
  logic              busy_o;
  logic              done_o;
  logic [31:0]       rdata_o;
  logic [ADDR_W-1:0] mem_a;
  logic [7:0]        mem_dout;
  logic              mem_wr;
  logic [7:0]        mem_din;

  modport slave (
    input  req_i, we_i, addr_i, size_i, unsigned_i, wdata_i, mem_din,
    output busy_o, done_o, rdata_o, mem_a, mem_dout, mem_wr
  );

  modport master (
    output req_i, we_i, addr_i, size_i, unsigned_i, wdata_i, mem_din,
    input  busy_o, done_o, rdata_o, mem_a, mem_dout, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Serialises 1/2/4-byte loads/stores onto an 8-bit RAM bus, little-endian.
// Optional MEM_CTRL_SIGN_EXT_EN: sign-extend loads when unsigned_i = 0.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  mem_ctrl_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state, state_nx;
  logic              we_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        cnt;
  logic [2:0]        last;
  logic [31:0]       rbuf;
  logic [31:0]       rmerge;
  logic [31:0]       rext;
  logic [1:0]        cap_lane;
  logic [1:0]        nxt_lane;
`ifdef MEM_CTRL_SIGN_EXT_EN
  logic              uns_q;
`endif

  always_comb begin
    case (size_q)
      2'b00:   last = 3'd0;
      2'b01:   last = 3'd1;
      default: last = 3'd3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // READ runs N+1 cycles: cycle cnt captures the byte addressed in cycle cnt-1.
  always_comb begin
    state_nx    = state;
    bus.busy_o  = (state != IDLE);
    bus.done_o  = (state == DONE);
    case (state)
      IDLE:    if (bus.req_i) state_nx = bus.we_i ? WRITE : READ;
      READ:    if (cnt == last + 3'd1) state_nx = DONE;
      WRITE:   if (cnt == last) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  assign cap_lane = 2'(cnt - 3'd1);
  assign nxt_lane = 2'(cnt + 3'd1);

  // The final byte arrives in the same cycle rdata_o is loaded, so merge it here.
  always_comb begin
    rmerge = rbuf;
    rmerge[{cap_lane, 3'b000} +: 8] = bus.mem_din;
  end

  always_comb begin
    case (size_q)
      2'b00:   rext = {24'h0, rmerge[7:0]};
      2'b01:   rext = {16'h0, rmerge[15:0]};
      default: rext = rmerge;
    endcase
`ifdef MEM_CTRL_SIGN_EXT_EN
    if (!uns_q) begin
      case (size_q)
        2'b00:   rext = {{24{rmerge[7]}}, rmerge[7:0]};
        2'b01:   rext = {{16{rmerge[15]}}, rmerge[15:0]};
        default: rext = rmerge;
      endcase
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q         <= 1'b0;
      size_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt          <= '0;
      rbuf         <= '0;
      bus.rdata_o  <= '0;
      bus.mem_a    <= '0;
      bus.mem_dout <= '0;
      bus.mem_wr   <= 1'b0;
`ifdef MEM_CTRL_SIGN_EXT_EN
      uns_q        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          bus.mem_wr <= 1'b0;
          if (bus.req_i) begin
            we_q      <= bus.we_i;
            size_q    <= bus.size_i;
            addr_q    <= bus.addr_i;
            wdata_q   <= bus.wdata_i;
            cnt       <= '0;
            bus.mem_a <= bus.addr_i;
`ifdef MEM_CTRL_SIGN_EXT_EN
            uns_q     <= bus.unsigned_i;
`endif
            if (bus.we_i) begin
              bus.mem_dout <= bus.wdata_i[7:0];
              bus.mem_wr   <= 1'b1;
            end
          end
        end
        READ: begin
          if (cnt != 3'd0) rbuf <= rmerge;
          if (cnt < last) bus.mem_a <= addr_q + ADDR_W'(cnt + 3'd1);
          if (cnt == last + 3'd1) bus.rdata_o <= rext;
          cnt <= cnt + 3'd1;
        end
        WRITE: begin
          if (cnt < last) begin
            bus.mem_a    <= addr_q + ADDR_W'(cnt + 3'd1);
            bus.mem_dout <= wdata_q[{nxt_lane, 3'b000} +: 8];
            bus.mem_wr   <= 1'b1;
          end else begin
            bus.mem_wr   <= 1'b0;
          end
          cnt <= cnt + 3'd1;
        end
        default: bus.mem_wr <= 1'b0;
      endcase
    end
  end

  logic unused_we;
  assign unused_we = we_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte-wide RAM model on the bus.
module tb_mem_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;
  logic [7:0] ram [0:1023];
  logic [31:0] exp_sb;

  mem_ctrl_if #(.ADDR_W(32)) bus ();

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_wr) ram[bus.mem_a[9:0]] <= bus.mem_dout;
    bus.mem_din <= ram[bus.mem_a[9:0]];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int unsigned n;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = a; bus.size_i = sz; bus.wdata_i = wd;
    step();
    bus.req_i = 1'b0;
    for (int unsigned k = 0; k < n; k++) begin
      check("st_wr", bus.mem_wr, 1'b1);
      check("st_addr", bus.mem_a, a + k);
      check("st_byte", bus.mem_dout, wd[8*k +: 8]);
      check("st_busy", bus.busy_o, 1'b1);
      check("st_nodone", bus.done_o, 1'b0);
      step();
    end
    check("st_done", bus.done_o, 1'b1);
    check("st_done_wr", bus.mem_wr, 1'b0);
    step();
    check("st_idle", bus.busy_o, 1'b0);
  endtask

  task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic uns,
                         input logic [31:0] exp);
    int unsigned n;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = a; bus.size_i = sz; bus.unsigned_i = uns;
    step();
    bus.req_i = 1'b0;
    for (int unsigned k = 0; k <= n; k++) begin
      if (k < n) check("ld_addr", bus.mem_a, a + k);
      check("ld_wr", bus.mem_wr, 1'b0);
      check("ld_nodone", bus.done_o, 1'b0);
      check("ld_busy", bus.busy_o, 1'b1);
      step();
    end
    check("ld_done", bus.done_o, 1'b1);
    check("ld_data", bus.rdata_o, exp);
    step();
    check("ld_idle", bus.busy_o, 1'b0);
    check("ld_hold", bus.rdata_o, exp);
  endtask

  initial begin
    rst = 1'b1;
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.size_i = '0;
    bus.unsigned_i = 1'b0; bus.wdata_i = '0;
    step();
    step();
    check("rst_busy", bus.busy_o, 1'b0);
    check("rst_done", bus.done_o, 1'b0);
    check("rst_rdata", bus.rdata_o, 32'h0);
    check("rst_a", bus.mem_a, 32'h0);
    check("rst_dout", bus.mem_dout, 8'h0);
    check("rst_wr", bus.mem_wr, 1'b0);
    rst = 1'b0;

    do_store(32'h0000_0100, 2'b10, 32'hDEAD_BEEF);
    do_load (32'h0000_0100, 2'b10, 1'b0, 32'hDEAD_BEEF);
    do_load (32'h0000_0101, 2'b01, 1'b1, 32'h0000_ADBE);
    do_load (32'h0000_0100, 2'b11, 1'b1, 32'hDEAD_BEEF);

    do_store(32'h0000_0010, 2'b00, 32'h1234_5680);
`ifdef MEM_CTRL_SIGN_EXT_EN
    exp_sb = 32'hFFFF_FF80;
`else
    exp_sb = 32'h0000_0080;
`endif
    do_load(32'h0000_0010, 2'b00, 1'b0, exp_sb);
    do_load(32'h0000_0010, 2'b00, 1'b1, 32'h0000_0080);

    do_store(32'hFFFF_FFFF, 2'b01, 32'h0000_1234);
    do_load (32'hFFFF_FFFF, 2'b01, 1'b0, 32'h0000_1234);

    // Reset during the second byte cycle of a word store.
    bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 32'h200; bus.size_i = 2'b10;
    bus.wdata_i = 32'hCAFE_F00D;
    step();
    bus.req_i = 1'b0;
    check("mid_wr0", bus.mem_wr, 1'b1);
    step();
    check("mid_a1", bus.mem_a, 32'h201);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_wr", bus.mem_wr, 1'b0);
    check("mid_busy", bus.busy_o, 1'b0);
    check("mid_done", bus.done_o, 1'b0);

    // Continuous byte-load requests: accepts every 4 cycles.
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 32'h100; bus.size_i = 2'b00;
    bus.unsigned_i = 1'b1;
    step();
    check("re_a", bus.mem_a, 32'h100);
    for (int unsigned i = 0; i < 12; i++) begin
      check("bb_busy", bus.busy_o, (i % 4) != 3);
      check("bb_done", bus.done_o, (i % 4) == 2);
      check("bb_wr", bus.mem_wr, 1'b0);
      if ((i % 4) == 2) check("bb_data", bus.rdata_o, 32'h0000_00EF);
      step();
    end
    bus.req_i = 1'b0;
    repeat (4) step();
    check("end_idle", bus.busy_o, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
